draw_arbiter: RTL and testbench

Round-robin scheduler and rectangle rasterizer that shares the single VGA pixel-plot port (X, Y, colour, plot) among three sprite drawers: character, maze walls and goal marker. Each drawer requests a filled box by presenting origin, size and colour. The arbiter grants one requester at a time and emits that box one pixel per clock. It then pulses a per-requester done. It sits between the sprite controllers and the VGA adapter.

---
 rtl/draw_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_draw_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin owner of the single VGA pixel-plot port.
// Three sprite drawers (character, maze walls, goal marker) request filled
// boxes; the granted box is rasterised one pixel per clock in row-major
// order, then the owner receives a one-cycle done pulse.
module draw_arbiter (
    input  logic        iClock,
    input  logic        iResetn,
    input  logic [2:0]  iReq,
    input  logic [23:0] iX,
    input  logic [20:0] iY,
    input  logic [23:0] iW,
    input  logic [20:0] iH,
    input  logic [17:0] iColour,
    output logic [2:0]  oGrant,
    output logic [2:0]  oDone,
    output logic [7:0]  oX,
    output logic [6:0]  oY,
    output logic [5:0]  oColour,
    output logic        oPlot,
    output logic        oBusy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  ptr_r, ptr_s;
    logic [2:0]  grant_r, grant_s;
    logic [7:0]  x0_r, x0_s;
    logic [6:0]  y0_r, y0_s;
    logic [7:0]  w_r, w_s;
    logic [6:0]  h_r, h_s;
    logic [5:0]  colour_r, colour_s;
    logic [7:0]  col_r, col_s;
    logic [6:0]  row_r, row_s;
    logic [1:0]  sel_s;
    logic [7:0]  pix_x_s;
    logic [6:0]  pix_y_s;

    // Successor of a requester index in the ring 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        case (idx)
            2'd0:    next_idx = 2'd1;
            2'd1:    next_idx = 2'd2;
            default: next_idx = 2'd0;
        endcase
    endfunction

    // First requester with its bit set, searching ptr, ptr+1, ptr+2.
    function automatic logic [1:0] pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = next_idx(ptr);
        c2 = next_idx(c1);
        if (req[ptr]) begin
            pick = ptr;
        end else if (req[c1]) begin
            pick = c1;
        end else begin
            pick = c2;
        end
    endfunction

    // One-hot encoding of a requester index.
    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            default: onehot = 3'b100;
        endcase
    endfunction

    // Index of the requester currently holding the grant.
    function automatic logic [1:0] grant_idx(input logic [2:0] grant);
        case (grant)
            3'b010:  grant_idx = 2'd1;
            3'b100:  grant_idx = 2'd2;
            default: grant_idx = 2'd0;
        endcase
    endfunction

    // Next-state logic: grant decision, box latch and raster scan counters.
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        grant_s  = grant_r;
        x0_s     = x0_r;
        y0_s     = y0_r;
        w_s      = w_r;
        h_s      = h_r;
        colour_s = colour_r;
        col_s    = col_r;
        row_s    = row_r;
        sel_s    = 2'd0;
        case (state_r)
            ST_IDLE: begin
                if (iReq != 3'b000) begin
                    sel_s   = pick(iReq, ptr_r);
                    grant_s = onehot(sel_s);
                    case (sel_s)
                        2'd0: begin
                            x0_s = iX[7:0];   y0_s = iY[6:0];   w_s = iW[7:0];
                            h_s  = iH[6:0];   colour_s = iColour[5:0];
                        end
                        2'd1: begin
                            x0_s = iX[15:8];  y0_s = iY[13:7];  w_s = iW[15:8];
                            h_s  = iH[13:7];  colour_s = iColour[11:6];
                        end
                        default: begin
                            x0_s = iX[23:16]; y0_s = iY[20:14]; w_s = iW[23:16];
                            h_s  = iH[20:14]; colour_s = iColour[17:12];
                        end
                    endcase
                    col_s = 8'd0;
                    row_s = 7'd0;
                    // An empty box skips the scan but still earns its done pulse.
                    if ((w_s == 8'd0) || (h_s == 7'd0)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_DRAW;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAW: begin
                if (col_r == (w_r - 8'd1)) begin
                    // Counters freeze on the final pixel so oX/oY hold it afterwards.
                    if (row_r == (h_r - 7'd1)) begin
                        state_s = ST_DONE;
                    end else begin
                        col_s = 8'd0;
                        row_s = row_r + 7'd1;
                    end
                end else begin
                    col_s = col_r + 8'd1;
                end
            end
            ST_DONE: begin
                grant_s = 3'b000;
                ptr_s   = next_idx(grant_idx(grant_r));
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any job without a done pulse.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_r  <= ST_IDLE;
            ptr_r    <= 2'd0;
            grant_r  <= 3'b000;
            x0_r     <= 8'd0;
            y0_r     <= 7'd0;
            w_r      <= 8'd0;
            h_r      <= 7'd0;
            colour_r <= 6'd0;
            col_r    <= 8'd0;
            row_r    <= 7'd0;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            grant_r  <= grant_s;
            x0_r     <= x0_s;
            y0_r     <= y0_s;
            w_r      <= w_s;
            h_r      <= h_s;
            colour_r <= colour_s;
            col_r    <= col_s;
            row_r    <= row_s;
        end
    end

    // Pixel outputs decoded from registered state; off-screen pixels are not plotted.
    always_comb begin
        pix_x_s = x0_r + col_r;
        pix_y_s = y0_r + row_r;
        oX      = pix_x_s;
        oY      = pix_y_s;
        oColour = colour_r;
        oGrant  = grant_r;
        oBusy   = (state_r != ST_IDLE);
        if (state_r == ST_DONE) begin
            oDone = grant_r;
        end else begin
            oDone = 3'b000;
        end
        if ((state_r == ST_DRAW) && (pix_x_s < 8'd160) && (pix_y_s < 7'd120)) begin
            oPlot = 1'b1;
        end else begin
            oPlot = 1'b0;
        end
    end

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter. A behavioural model (rotating pointer
// plus direct pixel-index arithmetic) predicts every cycle of each job.
module tb_draw_arbiter;

    logic        iClock;
    logic        iResetn;
    logic [2:0]  iReq;
    logic [23:0] iX;
    logic [20:0] iY;
    logic [23:0] iW;
    logic [20:0] iH;
    logic [17:0] iColour;
    logic [2:0]  oGrant;
    logic [2:0]  oDone;
    logic [7:0]  oX;
    logic [6:0]  oY;
    logic [5:0]  oColour;
    logic        oPlot;
    logic        oBusy;

    logic [7:0] bx [3];
    logic [6:0] by [3];
    logic [7:0] bw [3];
    logic [6:0] bh [3];
    logic [5:0] bc [3];

    int errors = 0;
    int checks = 0;
    int ptr_m  = 0;

    assign iX      = {bx[2], bx[1], bx[0]};
    assign iY      = {by[2], by[1], by[0]};
    assign iW      = {bw[2], bw[1], bw[0]};
    assign iH      = {bh[2], bh[1], bh[0]};
    assign iColour = {bc[2], bc[1], bc[0]};

    draw_arbiter dut (
        .iClock  (iClock),
        .iResetn (iResetn),
        .iReq    (iReq),
        .iX      (iX),
        .iY      (iY),
        .iW      (iW),
        .iH      (iH),
        .iColour (iColour),
        .oGrant  (oGrant),
        .oDone   (oDone),
        .oX      (oX),
        .oY      (oY),
        .oColour (oColour),
        .oPlot   (oPlot),
        .oBusy   (oBusy)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic set_box(input int r, input int x, input int y, input int w, input int h, input int c);
        bx[r] = 8'(x); by[r] = 7'(y); bw[r] = 8'(w); bh[r] = 7'(h); bc[r] = 6'(c);
    endtask

    // One job: model picks the winner, predicts every pixel, DONE and the IDLE after.
    task automatic run_job(input logic [2:0] req, input bit scramble);
        int g;
        int n;
        logic [7:0] ex, ew, px;
        logic [6:0] ey, eh, py;
        logic [5:0] ec;
        logic [2:0] oh;
        logic [28:0] exp_v, got_v;
        g = -1;
        for (int k = 0; k < 3; k++) begin
            if (g < 0 && req[(ptr_m + k) % 3]) g = (ptr_m + k) % 3;
        end
        if (g < 0) begin
            return;
        end
        ex = bx[g]; ey = by[g]; ew = bw[g]; eh = bh[g]; ec = bc[g];
        oh = 3'(1 << g);
        px = 8'd0; py = 7'd0;
        iReq = req;
        @(posedge iClock); #1;
        if (scramble) begin
            iReq = 3'($urandom);
            for (int r = 0; r < 3; r++) set_box(r, $urandom, $urandom, $urandom, $urandom, $urandom);
        end
        n = int'(ew) * int'(eh);
        if (n == 0) begin
            checks++;
            if ({oGrant, oDone, oPlot, oBusy} !== {oh, oh, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL zero_size_done g=%0d got grant=%b done=%b plot=%b busy=%b", g, oGrant, oDone, oPlot, oBusy);
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                px = ex + 8'(i % int'(ew));
                py = ey + 7'(i / int'(ew));
                exp_v = {oh, 3'b000, px, py, ec, (px < 8'd160) && (py < 7'd120), 1'b1};
                got_v = {oGrant, oDone, oX, oY, oColour, oPlot, oBusy};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL pixel g=%0d i=%0d got=%h want=%h", g, i, got_v, exp_v);
                end
                @(posedge iClock); #1;
            end
            exp_v = {oh, oh, px, py, ec, 1'b0, 1'b1};
            got_v = {oGrant, oDone, oX, oY, oColour, oPlot, oBusy};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL done_cycle g=%0d got=%h want=%h", g, got_v, exp_v);
            end
        end
        @(posedge iClock); #1;
        checks++;
        if ({oGrant, oDone, oPlot, oBusy} !== 8'b0) begin
            errors++;
            $display("FAIL idle_after g=%0d got grant=%b done=%b plot=%b busy=%b want all 0", g, oGrant, oDone, oPlot, oBusy);
        end
        ptr_m = (g + 1) % 3;
        iReq  = 3'b000;
    endtask

    task automatic test_reset();
        iResetn = 1'b0;
        iReq    = 3'b000;
        for (int r = 0; r < 3; r++) set_box(r, 0, 0, 0, 0, 0);
        #3;
        checks++;
        if ({oGrant, oDone, oX, oY, oColour, oPlot, oBusy} !== 29'd0) begin
            errors++;
            $display("FAIL reset_state got=%h want=0", {oGrant, oDone, oX, oY, oColour, oPlot, oBusy});
        end
        #9 iResetn = 1'b1;
        ptr_m = 0;
        @(posedge iClock); #1;
    endtask

    task automatic test_idle();
        iReq = 3'b000;
        for (int c = 0; c < 3; c++) begin
            @(posedge iClock); #1;
            checks++;
            if ({oGrant, oDone, oPlot, oBusy} !== 8'b0) begin
                errors++;
                $display("FAIL idle_hold c=%0d got grant=%b busy=%b want 0", c, oGrant, oBusy);
            end
        end
    endtask

    task automatic test_single();
        set_box(1, 20, 20, 4, 3, 6'b101011);
        iReq = 3'b010;
        run_job(3'b010, 1'b0);
    endtask

    task automatic test_back_to_back();
        set_box(0, 10, 10, 2, 2, 1);
        set_box(1, 40, 30, 2, 2, 2);
        set_box(2, 90, 60, 2, 2, 3);
        for (int j = 0; j < 4; j++) run_job(3'b111, 1'b0);
    endtask

    task automatic test_fairness();
        for (int j = 0; j < 4; j++) run_job(3'b101, 1'b0);
        for (int j = 0; j < 2; j++) run_job(3'b111, 1'b0);
    endtask

    task automatic test_clip();
        set_box(2, 158, 118, 4, 3, 6'b110011);
        run_job(3'b100, 1'b0);
    endtask

    task automatic test_zero();
        set_box(0, 5, 5, 0, 5, 7);
        run_job(3'b001, 1'b0);
        set_box(1, 5, 5, 5, 0, 7);
        run_job(3'b010, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_box(1, 30, 30, 10, 10, 6'b000111);
        iReq = 3'b010;
        @(posedge iClock); #1;
        for (int c = 0; c < 4; c++) begin
            @(posedge iClock); #1;
        end
        iResetn = 1'b0;
        #1;
        checks++;
        if ({oGrant, oDone, oX, oY, oColour, oPlot, oBusy} !== 29'd0) begin
            errors++;
            $display("FAIL reset_mid_immediate got=%h want=0", {oGrant, oDone, oX, oY, oColour, oPlot, oBusy});
        end
        @(posedge iClock); #1;
        checks++;
        if ({oDone, oPlot, oBusy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done got done=%b plot=%b busy=%b want 0", oDone, oPlot, oBusy);
        end
        #2 iResetn = 1'b1;
        ptr_m = 0;
        iReq  = 3'b000;
        @(posedge iClock); #1;
        set_box(1, 70, 50, 3, 2, 6'b010101);
        run_job(3'b010, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0] req;
        for (int j = 0; j < 25; j++) begin
            for (int r = 0; r < 3; r++) begin
                set_box(r, $urandom, $urandom, $urandom_range(0, 6), $urandom_range(0, 5), $urandom);
            end
            req = 3'($urandom_range(1, 7));
            run_job(req, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_fairness();
        test_clip();
        test_zero();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
